// File: rtl/result_display_bcd_pkg.sv
// Shared types and constants for the result display: FSM states, blank code, segment patterns and BCD helpers.
package result_display_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Double-dabble pre-shift correction: every nibble >= 5 gets +3, 4-bit wrap, no inter-nibble carry.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-high {g,f,e,d,c,b,a}; anything that is not a decimal digit is dark.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: W shift cycles after start; done stays high until the next start.
module bin2bcd_seq
  import result_display_bcd_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic [15:0]  bcd,
  output logic         done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic          run;
  logic [15:0]   adj;

  always_comb adj = bcd_adjust(bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      bcd  <= '0;
      cnt  <= CW'(W - 1);
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      bcd <= (adj << 1) | 16'(sh[W-1]);
      sh  <= sh << 1;
      if (cnt == '0) begin
        run  <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/result_display_bcd.sv
// Captures an ALU result, converts it to BCD (whole value or hi/lo halves) and scans a 4-digit 7-segment display.
module result_display_bcd
  import result_display_bcd_pkg::*;
#(
  parameter int unsigned WIDTH        = 6,
  parameter int unsigned REFRESH_BITS = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       sseg
);

  localparam int unsigned HALF    = WIDTH / 2;
  localparam int unsigned CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0]  AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t                  state;
  logic [CW-1:0]           bitcnt;
  logic [WIDTH-1:0]        data_q;
  logic                    mode_q;
  logic                    start;
  logic [WIDTH-1:0]        bin_full, bin_lo;
  logic [15:0]             bcd_full, bcd_lo;
  logic                    done_full, done_lo;
  logic [15:0]             disp, disp_new, disp_d;
  logic [REFRESH_BITS-1:0] cnt, cnt_d;
  logic [1:0]              sel_d;
  logic [3:0]              digit_d, an_d;
  logic [6:0]              seg_d;

  // In split mode the full-width converter carries the hi half.
  assign start    = (state == ST_LOAD);
  assign bin_full = mode_q ? WIDTH'(data_q[WIDTH-1:HALF]) : data_q;
  assign bin_lo   = WIDTH'(data_q[HALF-1:0]);

  bin2bcd_seq #(.W(WIDTH)) u_conv_full (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin_full),
    .bcd   (bcd_full),
    .done  (done_full)
  );

  bin2bcd_seq #(.W(WIDTH)) u_conv_lo (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin_lo),
    .bcd   (bcd_lo),
    .done  (done_lo)
  );

  // Digit formatting; the lo half never exceeds two digits, so its upper nibbles are masked off.
  always_comb begin
    disp_new = bcd_full;
    if (mode_q) begin
      disp_new = {bcd_full[7:0], 8'h00} | (bcd_lo & 16'h00FF);
    end else if (bcd_full[15:12] == 4'd0) begin
      disp_new[15:12] = BLANK;
      if (bcd_full[11:8] == 4'd0) begin
        disp_new[11:8] = BLANK;
        if (bcd_full[7:4] == 4'd0) disp_new[7:4] = BLANK;
      end
    end
  end

  // Segment outputs are decoded from next-cycle state so new digits appear with busy falling.
  always_comb begin
    disp_d  = (state == ST_DONE && done_full && done_lo) ? disp_new : disp;
    cnt_d   = cnt + REFRESH_BITS'(1);
    sel_d   = cnt_d[REFRESH_BITS-1 -: 2];
    digit_d = disp_d[{sel_d, 2'b00} +: 4];
    an_d    = 4'(4'b0001 << sel_d);
    seg_d   = seg_of(digit_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      bitcnt <= '0;
      data_q <= '0;
      mode_q <= 1'b0;
      disp   <= {4{BLANK}};
      cnt    <= '0;
      an     <= AN_OFF;
      sseg   <= SEG_OFF;
    end else begin
      cnt  <= cnt_d;
      disp <= disp_d;
      an   <= ACTIVE_LOW ? ~an_d : an_d;
      sseg <= ACTIVE_LOW ? ~seg_d : seg_d;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            data_q <= data;
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bitcnt <= CW'(WIDTH - 1);
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bitcnt == '0) state <= ST_DONE;
          else              bitcnt <= bitcnt - CW'(1);
        end
        ST_DONE: begin
          if (done_full && done_lo) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_display_bcd.sv
// Scoreboard bench: stimulus queues expected digits, a negedge monitor checks busy length and every scanned digit.
module tb_result_display_bcd;

  localparam int unsigned W    = 6;
  localparam int unsigned HALF = W / 2;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic         mode  = 1'b0;
  logic [W-1:0] data  = '0;
  logic         busy;
  logic [3:0]   an;
  logic [6:0]   sseg;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];

  int m_cnt  = 0;
  bit m_off  = 1'b1;
  bit chk_en = 1'b0;

  result_display_bcd #(.WIDTH(W), .REFRESH_BITS(4), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .data  (data),
    .mode  (mode),
    .busy  (busy),
    .an    (an),
    .sseg  (sseg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] tb_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected digits {d3,d2,d1,d0}; code 15 is a blank digit.
  function automatic logic [15:0] model(input logic m, input int v);
    logic [15:0] r;
    int p, hi, lo;
    r = '0;
    if (!m) begin
      p = 1;
      for (int i = 0; i < 4; i++) begin
        r[4*i +: 4] = 4'((v / p) % 10);
        if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
        p = p * 10;
      end
    end else begin
      hi = v / (1 << HALF);
      lo = v % (1 << HALF);
      r = {4'(hi / 10), 4'(hi % 10), 4'(lo / 10), 4'(lo % 10)};
    end
    return r;
  endfunction

  // Scan model: counter of REFRESH_BITS=4 bits, outputs dark for one cycle after each reset edge.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= 0;
      m_off  <= 1'b1;
      chk_en <= 1'b1;
    end else begin
      m_cnt <= (m_cnt + 1) % 16;
      m_off <= 1'b0;
    end
  end

  initial begin : monitor
    logic [15:0] cur;
    bit          busy_prev;
    int          busy_len;
    int          k;
    int          exp_disp;
    cur       = 16'hFFFF;
    busy_prev = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_off) begin
          exp_q.delete();
          cur       = 16'hFFFF;
          busy_prev = 1'b0;
          busy_len  = 0;
          check("busy_in_reset", int'(busy), 0);
          exp_disp = {4'hF, 7'h7F};
        end else begin
          if (busy_prev && !busy) begin
            check("busy_length", busy_len, W + 2);
            busy_len = 0;
            if (exp_q.size() == 0) check("unexpected_result", 0, 1);
            else cur = exp_q.pop_front();
          end
          if (busy) busy_len++;
          busy_prev = busy;
          k = m_cnt / 4;
          exp_disp = {~(4'(4'b0001 << k)), ~tb_seg(cur[4*k +: 4])};
        end
        check("display_an_sseg", int'({an, sseg}), exp_disp);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("idle_reached", int'(busy), 0);
  endtask

  // One accepted transaction; ign_at in 1..W+2 drives an extra valid on that busy cycle.
  task automatic run_txn(input logic m, input logic [W-1:0] d, input int ign_at);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    mode  = m;
    exp_q.push_back(model(m, int'(d)));
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      valid = (k == ign_at);
      if (k == ign_at) begin
        data = W'($urandom);
        mode = 1'($urandom);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (17) @(negedge clk);

    run_txn(1'b0, 6'd49, 0);
    repeat (16) @(negedge clk);
    run_txn(1'b1, 6'b011010, 0);
    repeat (16) @(negedge clk);
    run_txn(1'b0, 6'd0, 0);
    repeat (16) @(negedge clk);

    run_txn(1'b0, 6'd49, 3);
    repeat (16) @(negedge clk);
    run_txn(1'b0, 6'd7, W + 2);
    repeat (16) @(negedge clk);
    run_txn(1'b1, 6'd63, 0);

    // Reset on the fourth SHIFT cycle aborts the conversion and blanks the display.
    @(negedge clk);
    valid = 1'b1;
    data  = 6'd58;
    mode  = 1'b0;
    exp_q.push_back(model(1'b0, 58));
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (18) @(negedge clk);
    run_txn(1'b0, 6'd35, 0);

    for (int t = 0; t < 20; t++) begin
      run_txn(1'($urandom), W'($urandom_range(0, 63)), int'($urandom_range(0, W + 2)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
